// File: rtl/apb_completer_mem.sv
// APB completer backed by a register-array memory with a fixed number of wait
// states per access and PSLVERR on addresses beyond MEM_DEPTH.
module apb_completer_mem #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 8,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(MEM_DEPTH);
    localparam logic [3:0] WS_L = 4'(WAIT_STATES);

    typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] mem_q [0:MEM_DEPTH-1];

    logic in_range_s;
    logic ready_s;
    logic commit_s;

    assign in_range_s = ({1'b0, PADDR} < DEPTH_L);
    assign ready_s    = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign commit_s   = ready_s && PSEL && PENABLE && write_q && !err_q;

    // Outputs derive only from registers; read data is exposed on the completing cycle.
    assign PREADY  = ready_s;
    assign PRDATA  = ready_s ? rdata_q : {DATA_WIDTH{1'b0}};
    assign PSLVERR = ready_s && err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                // PSEL with PENABLE already high has no setup phase and is ignored.
                if (PSEL && !PENABLE) begin
                    state_d = ACCESS;
                    cnt_d   = WS_L;
                    addr_d  = PADDR;
                    write_d = PWRITE;
                    wdata_d = PWDATA;
                    err_d   = !in_range_s;
                    if (!PWRITE && in_range_s) begin
                        rdata_d = mem_q[PADDR[IDX_W-1:0]];
                    end else begin
                        rdata_d = {DATA_WIDTH{1'b0}};
                    end
                end else begin
                    rdata_d = {DATA_WIDTH{1'b0}};
                end
            end
            ACCESS: begin
                if (PSEL && PENABLE) begin
                    if (cnt_q == 4'd0) begin
                        state_d = IDLE;
                        rdata_d = {DATA_WIDTH{1'b0}};
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end else begin
                    state_d = IDLE;
                    rdata_d = {DATA_WIDTH{1'b0}};
                end
            end
            default: begin
                state_d = IDLE;
                rdata_d = {DATA_WIDTH{1'b0}};
            end
        endcase
    end

    // Transfer control registers.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= {ADDR_WIDTH{1'b0}};
            write_q <= 1'b0;
            wdata_q <= {DATA_WIDTH{1'b0}};
            rdata_q <= {DATA_WIDTH{1'b0}};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage array; writes commit on the completion edge using the latched address/data.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            if (commit_s) begin
                mem_q[addr_q[IDX_W-1:0]] <= wdata_q;
            end
        end
    end

endmodule

// File: tb/tb_apb_completer_mem.sv
// Directed bench: a WAIT_STATES=0 instance (index 0) and a WAIT_STATES=3 instance (index 1).
module tb_apb_completer_mem;

    logic       PCLK;
    logic       PRESET;
    logic       psel    [2];
    logic       penable [2];
    logic       pwrite  [2];
    logic [8:0] paddr   [2];
    logic [7:0] pwdata  [2];
    logic       pready  [2];
    logic [7:0] prdata  [2];
    logic       pslverr [2];

    int n_vec;
    int n_err;

    typedef struct {
        int         d;
        bit         w;
        logic [8:0] a;
        logic [7:0] wd;
        logic [7:0] rd;
        bit         err;
    } vec_t;

    vec_t tbl [12];

    apb_completer_mem #(.ADDR_WIDTH(9), .DATA_WIDTH(8), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(penable[0]),
        .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]),
        .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0])
    );

    apb_completer_mem #(.ADDR_WIDTH(9), .DATA_WIDTH(8), .MEM_DEPTH(256), .WAIT_STATES(3)) u_dut1 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(penable[1]),
        .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]),
        .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1])
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic idle_checks(input int d, input string tag);
        chk({tag, " idle PREADY"},  {31'd0, pready[d]},  32'd0);
        chk({tag, " idle PRDATA"},  {24'd0, prdata[d]},  32'd0);
        chk({tag, " idle PSLVERR"}, {31'd0, pslverr[d]}, 32'd0);
    endtask

    // Full transfer starting now (just after an edge); bus values are scrambled during access.
    task automatic xfer(input int d, input bit w, input logic [8:0] a, input logic [7:0] wd,
                        input logic [7:0] erd, input bit eerr, input bit idle_after, input string tag);
        int ws;
        int cyc;
        ws = (d == 0) ? 0 : 3;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = w; paddr[d] = a; pwdata[d] = wd;
        tick();
        penable[d] = 1'b1; paddr[d] = ~a; pwdata[d] = ~wd;
        cyc = 1;
        while (!pready[d] && cyc < 20) begin
            chk({tag, " wait PRDATA"},  {24'd0, prdata[d]},  32'd0);
            chk({tag, " wait PSLVERR"}, {31'd0, pslverr[d]}, 32'd0);
            tick();
            cyc++;
        end
        chk({tag, " PREADY seen"}, {31'd0, pready[d]}, 32'd1);
        chk({tag, " latency"}, cyc, ws + 1);
        chk({tag, " PRDATA"},  {24'd0, prdata[d]},  {24'd0, erd});
        chk({tag, " PSLVERR"}, {31'd0, pslverr[d]}, {31'd0, eerr});
        tick();
        if (idle_after) begin
            psel[d] = 1'b0; penable[d] = 1'b0;
            idle_checks(d, tag);
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        tbl[0]  = '{0, 1'b1, 9'h010, 8'hA5, 8'h00, 1'b0};
        tbl[1]  = '{0, 1'b0, 9'h010, 8'h00, 8'hA5, 1'b0};
        tbl[2]  = '{1, 1'b1, 9'h0FF, 8'h3C, 8'h00, 1'b0};
        tbl[3]  = '{1, 1'b0, 9'h0FF, 8'h00, 8'h3C, 1'b0};
        tbl[4]  = '{0, 1'b1, 9'h100, 8'h77, 8'h00, 1'b1};
        tbl[5]  = '{0, 1'b0, 9'h000, 8'h00, 8'h00, 1'b0};
        tbl[6]  = '{0, 1'b0, 9'h1FF, 8'h00, 8'h00, 1'b1};
        tbl[7]  = '{1, 1'b1, 9'h100, 8'h77, 8'h00, 1'b1};
        tbl[8]  = '{0, 1'b1, 9'h020, 8'h11, 8'h00, 1'b0};
        tbl[9]  = '{1, 1'b1, 9'h020, 8'h11, 8'h00, 1'b0};
        tbl[10] = '{0, 1'b0, 9'h0FF, 8'h00, 8'h00, 1'b0};
        tbl[11] = '{1, 1'b0, 9'h000, 8'h00, 8'h00, 1'b0};

        for (int i = 0; i < 2; i++) begin
            psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
            paddr[i] = 9'h000; pwdata[i] = 8'h00;
        end
        PRESET = 1'b1;
        tick();
        tick();
        idle_checks(0, "reset d0");
        idle_checks(1, "reset d1");
        PRESET = 1'b0;
        tick();

        // Reset asserted mid-cycle while a read is presenting data.
        xfer(0, 1'b1, 9'h010, 8'hA5, 8'h00, 1'b0, 1'b1, "pre-reset write");
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = 9'h010;
        tick();
        penable[0] = 1'b1;
        chk("pre-reset read PREADY", {31'd0, pready[0]}, 32'd1);
        chk("pre-reset read PRDATA", {24'd0, prdata[0]}, 32'h0000_00A5);
        #2;
        PRESET = 1'b1;
        #1;
        idle_checks(0, "async reset");
        psel[0] = 1'b0; penable[0] = 1'b0;
        tick();
        PRESET = 1'b0;
        tick();
        xfer(0, 1'b0, 9'h010, 8'h00, 8'h00, 1'b0, 1'b1, "post-reset read 010");
        xfer(0, 1'b0, 9'h005, 8'h00, 8'h00, 1'b0, 1'b1, "post-reset read 005");

        for (int i = 0; i < 12; i++) begin
            xfer(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].rd, tbl[i].err, 1'b1,
                 $sformatf("vec%0d", i));
        end

        // Abort: PENABLE/PSEL dropped during a wait state of a write.
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 9'h020; pwdata[1] = 8'h55;
        tick();
        penable[1] = 1'b1;
        chk("abort access1 PREADY", {31'd0, pready[1]}, 32'd0);
        tick();
        chk("abort access2 PREADY", {31'd0, pready[1]}, 32'd0);
        psel[1] = 1'b0; penable[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("abort after PREADY", {31'd0, pready[1]}, 32'd0);
        end
        xfer(1, 1'b0, 9'h020, 8'h00, 8'h11, 1'b0, 1'b1, "abort readback");

        // Protocol violation: select and enable together with no setup phase.
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 9'h030; pwdata[0] = 8'h99;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("noSetup PREADY", {31'd0, pready[0]}, 32'd0);
        end
        psel[0] = 1'b0; penable[0] = 1'b0;
        tick();
        xfer(0, 1'b0, 9'h030, 8'h00, 8'h00, 1'b0, 1'b1, "noSetup readback");

        // Back-to-back transfers with no idle cycles in between.
        xfer(0, 1'b1, 9'h001, 8'hAA, 8'h00, 1'b0, 1'b0, "b2b w001");
        xfer(0, 1'b1, 9'h002, 8'hBB, 8'h00, 1'b0, 1'b0, "b2b w002");
        xfer(0, 1'b1, 9'h003, 8'hCC, 8'h00, 1'b0, 1'b0, "b2b w003");
        xfer(0, 1'b0, 9'h003, 8'h00, 8'hCC, 1'b0, 1'b0, "b2b r003");
        xfer(0, 1'b0, 9'h001, 8'h00, 8'hAA, 1'b0, 1'b0, "b2b r001");
        xfer(0, 1'b0, 9'h002, 8'h00, 8'hBB, 1'b0, 1'b1, "b2b r002");
        xfer(1, 1'b1, 9'h004, 8'h5A, 8'h00, 1'b0, 1'b0, "b2b ws w004");
        xfer(1, 1'b0, 9'h004, 8'h00, 8'h5A, 1'b0, 1'b1, "b2b ws r004");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
